// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants, coordinate widths and capture FSM states.
// Used by hvsync_generator and vga_capture.
package vga_timing_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_H_TOTAL  = 800;
   localparam int VGA_V_TOTAL  = 525;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_H_START  = 144;
   localparam int VGA_V_START  = 35;

   localparam int X_W   = 10;
   localparam int Y_W   = 9;
   localparam int PIX_W = 3;
   localparam int CNT_W = 10;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } cap_state_t;

endpackage

// File: rtl/vga_sync_detect.sv
// Registers one incoming sync, normalises it to active-high and flags the
// cycle on which the registered sync becomes asserted.
module vga_sync_detect
   import vga_timing_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_in,
   output logic sync_edge
);

   logic sync_p0;
   logic sync_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= ACTIVE_LOW ? ~sync_in : sync_in;
         sync_p1 <= sync_p0;
      end
   end

   assign sync_edge = sync_p0 & ~sync_p1;

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: locks to hsync/vsync timing and emits one framebuffer write
// per active pixel. Optional per-frame CRC-8 when VGA_CAPTURE_CRC_EN is defined.
module vga_capture
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE        = VGA_H_ACTIVE,
   parameter int V_ACTIVE        = VGA_V_ACTIVE,
   parameter int H_TOTAL         = VGA_H_TOTAL,
   parameter int V_TOTAL         = VGA_V_TOTAL,
   parameter int H_START         = VGA_H_START,
   parameter int V_START         = VGA_V_START,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic             wr_en,
   output logic [X_W-1:0]   wr_x,
   output logic [Y_W-1:0]   wr_y,
   output logic [PIX_W-1:0] wr_pixel,
   output logic             frame_start,
   output logic             locked,
   output logic             err
`ifdef VGA_CAPTURE_CRC_EN
   ,
   output logic [7:0]       frame_crc,
   output logic             crc_valid
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] H_TOT   = CNT_W'(H_TOTAL);
   localparam logic [CNT_W-1:0] V_TOT   = CNT_W'(V_TOTAL);
   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_BEG   = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_START + H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_BEG   = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_START + V_ACTIVE - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_MAX) ? c : c + CNT_W'(1);
   endfunction

   // Stage p0: registered inputs and sync assert edges
   logic [PIX_W-1:0] pixel_p0;
   logic             hs_edge_p0;
   logic             vs_edge_p0;

   always_ff @(posedge clk) begin
      pixel_p0 <= pixel_in;
   end

   vga_sync_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hs_detect (
      .clk       (clk),
      .rst       (rst),
      .sync_in   (hsync_in),
      .sync_edge (hs_edge_p0)
   );

   vga_sync_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vs_detect (
      .clk       (clk),
      .rst       (rst),
      .sync_in   (vsync_in),
      .sync_edge (vs_edge_p0)
   );

   cap_state_t       state;
   logic [CNT_W-1:0] hcount_q;
   logic [CNT_W-1:0] vcount_q;
   logic             h_seen;
   logic             meas_bad;

   logic [CNT_W-1:0] h_cur;
   logic [CNT_W-1:0] v_cur;
   logic [CNT_W-1:0] x_off;
   logic [CNT_W-1:0] y_off;
   logic             checking;
   logic             line_bad;
   logic             frame_bad;
   logic             timeout;
   logic             viol;
   logic             active;
   logic             lock_now;
   logic             stay_locked;
   logic             fs_now;

   // Raster position of the sample currently in p0
   always_comb begin
      h_cur = hs_edge_p0 ? '0 : sat_inc(hcount_q);
      v_cur = vcount_q;
      if (vs_edge_p0)
         v_cur = '0;
      else if (hs_edge_p0)
         v_cur = sat_inc(vcount_q);
   end

   // h_seen masks the partial line that precedes the first hsync after SEARCH
   assign checking  = (state != ST_SEARCH);
   assign line_bad  = checking && hs_edge_p0 && h_seen && (hcount_q != H_LAST);
   assign frame_bad = checking && vs_edge_p0 && (vcount_q != V_LAST);
   assign timeout   = checking && ((!hs_edge_p0 && (h_cur == H_TOT)) ||
                                   (!vs_edge_p0 && (v_cur == V_TOT)));
   assign viol      = line_bad || frame_bad || timeout;

   assign active      = (h_cur >= H_BEG) && (h_cur <= H_END) &&
                        (v_cur >= V_BEG) && (v_cur <= V_END);
   assign lock_now    = (state == ST_MEASURE) && vs_edge_p0 && !viol && !meas_bad;
   assign stay_locked = ((state == ST_LOCKED) && !viol) || lock_now;
   assign fs_now      = stay_locked && vs_edge_p0;
   assign x_off       = h_cur - H_BEG;
   assign y_off       = v_cur - V_BEG;

   // Stage p1: FSM, counters and registered write outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_SEARCH;
         hcount_q    <= '0;
         vcount_q    <= '0;
         h_seen      <= 1'b0;
         meas_bad    <= 1'b0;
         wr_en       <= 1'b0;
         wr_x        <= '0;
         wr_y        <= '0;
         wr_pixel    <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else begin
         hcount_q <= h_cur;
         vcount_q <= v_cur;

         if (state == ST_SEARCH)
            h_seen <= hs_edge_p0 && vs_edge_p0;
         else if (hs_edge_p0)
            h_seen <= 1'b1;

         case (state)
            ST_SEARCH: begin
               meas_bad <= 1'b0;
               if (vs_edge_p0)
                  state <= ST_MEASURE;
            end
            ST_MEASURE: begin
               if (timeout) begin
                  state    <= ST_SEARCH;
                  meas_bad <= 1'b0;
               end else if (vs_edge_p0) begin
                  if (lock_now)
                     state <= ST_LOCKED;
                  meas_bad <= 1'b0;
               end else if (line_bad) begin
                  meas_bad <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (viol)
                  state <= ST_SEARCH;
            end
            default: state <= ST_SEARCH;
         endcase

         err         <= viol;
         locked      <= stay_locked;
         frame_start <= fs_now;
         wr_en       <= stay_locked && active;
         wr_x        <= x_off[X_W-1:0];
         wr_y        <= y_off[Y_W-1:0];
         wr_pixel    <= pixel_p0;
      end
   end

`ifdef VGA_CAPTURE_CRC_EN
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction

   logic [7:0] crc_acc;
   logic       crc_frame_ok;

   // crc_frame_ok: the frame now accumulating began and has stayed in LOCKED
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_acc      <= '0;
         crc_frame_ok <= 1'b0;
         frame_crc    <= '0;
         crc_valid    <= 1'b0;
      end else begin
         crc_valid <= 1'b0;
         if (fs_now) begin
            if (crc_frame_ok)
               frame_crc <= crc_acc;
            crc_valid    <= crc_frame_ok;
            crc_acc      <= '0;
            crc_frame_ok <= 1'b1;
         end else begin
            if (wr_en)
               crc_acc <= crc8_byte(crc_acc, {{(8-PIX_W){1'b0}}, wr_pixel});
            if (!stay_locked)
               crc_frame_ok <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced raster (40x20 total, 24x12 active).
// Define VGA_CAPTURE_CRC_EN to also check the per-frame CRC outputs.
module tb_vga_capture;

   localparam int H_A  = 24;
   localparam int V_A  = 12;
   localparam int H_T  = 40;
   localparam int V_T  = 20;
   localparam int H_S  = 10;
   localparam int V_S  = 4;
   localparam int HS_W = 4;
   localparam int VS_W = 2;
   localparam int RST_X = H_S + 12;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] pixel_in;
   logic       hsync_in;
   logic       vsync_in;
   logic       wr_en;
   logic [9:0] wr_x;
   logic [8:0] wr_y;
   logic [2:0] wr_pixel;
   logic       frame_start;
   logic       locked;
   logic       err;
`ifdef VGA_CAPTURE_CRC_EN
   logic [7:0] frame_crc;
   logic       crc_valid;
`endif

   always #5 clk = ~clk;

   vga_capture #(
      .H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_TOTAL(H_T), .V_TOTAL(V_T),
      .H_START(H_S), .V_START(V_S), .SYNC_ACTIVE_LOW(1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pixel_in    (pixel_in),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .wr_en       (wr_en),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .wr_pixel    (wr_pixel),
      .frame_start (frame_start),
      .locked      (locked),
      .err         (err)
`ifdef VGA_CAPTURE_CRC_EN
      ,
      .frame_crc   (frame_crc),
      .crc_valid   (crc_valid)
`endif
   );

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [2:0] p;
   } wr_t;

   wr_t        sb_q[$];
   logic [7:0] crc_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         err_seen = 0;
   int         fs_seen  = 0;
   int         exp_err  = 0;
   int         exp_fs   = 0;
   logic       err_prev = 1'b0;
   logic       sof = 1'b0;
   logic       sof_d1 = 1'b0, sof_d2 = 1'b0;
   logic [2:0] pix_d1 = '0, pix_d2 = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [2:0] pix);
      logic [7:0] data;
      logic       fb;
      data = {5'b0, pix};
      for (int b = 7; b >= 0; b--) begin
         fb  = crc[7] ^ data[b];
         crc = {crc[6:0], 1'b0};
         if (fb) crc = crc ^ 8'h07;
      end
      return crc;
   endfunction

   always @(posedge clk) begin
      pix_d1 <= pixel_in;
      pix_d2 <= pix_d1;
      sof_d1 <= sof;
      sof_d2 <= sof_d1;
   end

   always @(negedge clk) begin
      if (err_prev)
         chk("post_err_wr_en_locked", 32'({wr_en, locked}), 32'd0);
      if (wr_en) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            wr_t e;
            e = sb_q.pop_front();
            chk("wr_x", 32'(wr_x), 32'(e.x));
            chk("wr_y", 32'(wr_y), 32'(e.y));
            chk("wr_pixel", 32'(wr_pixel), 32'(e.p));
         end
         chk("latency2", 32'(wr_pixel), 32'(pix_d2));
      end
      if (err) begin
         err_seen++;
         chk("err_locked", 32'(locked), 32'd0);
      end
      if (frame_start) begin
         fs_seen++;
         chk("fs_align", 32'(sof_d2), 32'd1);
      end
`ifdef VGA_CAPTURE_CRC_EN
      if (crc_valid) begin
         chk("crc_expected", 32'(crc_q.size() != 0), 32'd1);
         if (crc_q.size() != 0)
            chk("frame_crc", 32'(frame_crc), 32'(crc_q.pop_front()));
      end
`endif
      err_prev = err;
   end

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      chk({tag, "_wr_x"}, 32'(wr_x), 32'd0);
      chk({tag, "_wr_y"}, 32'(wr_y), 32'd0);
      chk({tag, "_wr_pixel"}, 32'(wr_pixel), 32'd0);
      chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
`ifdef VGA_CAPTURE_CRC_EN
      chk({tag, "_crc_valid"}, 32'(crc_valid), 32'd0);
`endif
   endtask

   // mode 0: x[2:0], 1: all zero, 2: random. -1 disables an injection.
   task automatic drive_frame(input int mode, input bit exp_wr, input int short_line,
                              input int drop_line, input int rst_line, input int n_lines);
      int         kill;
      int         len;
      bit         killed;
      bit         last_push;
      bit         hs_act;
      logic [7:0] crc;
      logic [2:0] pix;
      kill = V_T;
      if (short_line >= 0) begin kill = short_line + 1; exp_err++; end
      if (drop_line >= 0) begin kill = drop_line; exp_err++; end
      killed    = 1'b0;
      last_push = 1'b0;
      crc       = 8'h00;
      if (exp_wr) exp_fs++;
      for (int cy = 0; cy < n_lines; cy++) begin
         len = (cy == short_line) ? H_T - 1 : H_T;
         for (int cx = 0; cx < len; cx++) begin
            @(posedge clk);
            #1;
            if (rst) begin
               chk_outputs_zero("midline_rst");
               rst = 1'b0;
            end
            case (mode)
               0:       pix = 3'(cx);
               1:       pix = 3'd0;
               default: pix = 3'($urandom_range(0, 7));
            endcase
            pixel_in = pix;
            hs_act   = (cx < HS_W) && !(drop_line >= 0 && cy >= drop_line && cy < drop_line + 3);
            hsync_in = ~hs_act;
            vsync_in = ~(cy < VS_W);
            sof      = (cx == 0) && (cy == 0);
            if (cy == rst_line && cx == RST_X) begin
               rst = 1'b1;
               if (last_push) void'(sb_q.pop_back());
               killed = 1'b1;
            end
            if (exp_wr && !killed && cy < kill && cx >= H_S && cx < H_S + H_A &&
                cy >= V_S && cy < V_S + V_A) begin
               sb_q.push_back('{x: 10'(cx - H_S), y: 9'(cy - V_S), p: pix});
               crc = crc_model(crc, pix);
               last_push = 1'b1;
            end else begin
               last_push = 1'b0;
            end
         end
      end
      if (exp_wr && !killed && kill == V_T && n_lines == V_T)
         crc_q.push_back(crc);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      chk("err_count", 32'(err_seen), 32'(exp_err));
      chk("fs_count", 32'(fs_seen), 32'(exp_fs));
      chk("locked_eof", 32'(locked), 32'(exp_wr && !killed && kill == V_T));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      pixel_in = '0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      rst = 1'b0;
      repeat (5) @(posedge clk);

      drive_frame(0, 1'b0, -1, -1, -1, V_T);  // SEARCH -> MEASURE
      drive_frame(0, 1'b1, -1, -1, -1, V_T);  // locks at this vs edge
      drive_frame(1, 1'b1, -1, -1, -1, V_T);
      drive_frame(2, 1'b1,  6, -1, -1, V_T);  // 39-clock line
      drive_frame(0, 1'b0, -1, -1, -1, V_T);
      drive_frame(0, 1'b1, -1, -1, -1, V_T);
      drive_frame(2, 1'b1, -1,  8, -1, V_T);  // hsync missing
      drive_frame(0, 1'b0, -1, -1, -1, V_T);
      drive_frame(0, 1'b1, -1, -1,  6, V_T);  // reset mid active line
      drive_frame(2, 1'b0, -1, -1, -1, V_T);
      drive_frame(2, 1'b1, -1, -1, -1, V_T);
      drive_frame(1, 1'b1, -1, -1, -1, V_T);
      drive_frame(0, 1'b1, -1, -1, -1, 1);

      repeat (5) @(posedge clk);
      #1;
      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef VGA_CAPTURE_CRC_EN
      chk("final_crc_q_empty", 32'(crc_q.size()), 32'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive side of the team's 640x480 VGA output (3-bit pixel, hsync, vsync, 25 MHz pixel clock).
- Locks to incoming sync timing, tracks raster position, emits one framebuffer write per active pixel (x, y, pixel).
- Used for loopback test of the VGA output path and for capturing external 3-bit video into the framebuffer.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
H_TOTAL, 800, clocks per line (sync+porches+active)
V_TOTAL, 525, lines per frame
H_START, 144, clocks from hsync assert edge to first active pixel (sync 96 + back porch 48)
V_START, 35, lines from vsync assert edge to first active line (sync 2 + back porch 33)
SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low

Ports:
clk  in  1  pixel clock, 25 MHz
rst  in  1  synchronous, active-high reset
pixel_in  in  3  incoming pixel
hsync_in  in  1  incoming hsync
vsync_in  in  1  incoming vsync
wr_en  out  1  framebuffer write strobe
wr_x  out  10  column 0..639
wr_y  out  9  row 0..479
wr_pixel  out  3  pixel to write
frame_start  out  1  one-cycle pulse at start of each captured frame
locked  out  1  timing locked, writes enabled
err  out  1  one-cycle pulse on timing violation while MEASURE/LOCKED

Behaviour:
- Input stage: pixel/hsync/vsync registered once; syncs normalised to active-high per SYNC_ACTIVE_LOW. hs_edge/vs_edge = registered sync asserted this cycle, deasserted previous cycle.
- hcount (10b): 0 on hs_edge, else +1, saturating at 1023. Sample with hs_edge has h=0.
- vcount (10b): 0 on vs_edge (overrides a coincident hs_edge), else +1 on hs_edge, saturating at 1023. Line with vs_edge is v=0.
- Line check at hs_edge: hcount+1 == H_TOTAL. Timeout: hcount reaching H_TOTAL without hs_edge = violation. Frame check at vs_edge: vcount+1 == V_TOTAL. vcount reaching V_TOTAL without vs_edge = violation. The first partial line/frame after SEARCH is not checked.
- FSM:
  - SEARCH (reset state) -> MEASURE on vs_edge.
  - MEASURE: any violation -> err pulse, restart MEASURE (at vs_edge) or return to SEARCH (timeout). vs_edge with all lines of the frame good -> LOCKED.
  - LOCKED: any violation -> err pulse, locked=0, wr_en=0 from next cycle, go to SEARCH.
- Active window: h in [H_START, H_START+H_ACTIVE-1] and v in [V_START, V_START+V_ACTIVE-1].
- Writes occur only in LOCKED: wr_x = h-H_START, wr_y = v-V_START, wr_pixel = registered pixel. Outputs are registered. Latency pixel_in -> wr_pixel is 2 clk. Exactly H_ACTIVE*V_ACTIVE = 307200 writes per good frame.
- frame_start pulses on every vs_edge at which the state is, or becomes, LOCKED. It is aligned with the vs_edge output cycle.
- locked = (state == LOCKED), registered.
- Reset: every output 0, counters 0, state SEARCH. Reset mid-line: wr_en is 0 the cycle after rst is sampled. Relock requires a full SEARCH -> MEASURE -> LOCKED sequence (2 vs_edges).

Optional Feature:
- Macro: VGA_CAPTURE_CRC_EN.
- Defined: adds ports frame_crc out 8 and crc_valid out 1.
  - CRC-8, polynomial 0x07, MSB-first, init 0x00, updated on each wr_en with byte {5'b0, wr_pixel}.
  - At frame_start: frame_crc latches the previous frame's CRC and crc_valid pulses 1 cycle, only if that whole frame was captured in LOCKED. The accumulator then reinitialises.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package vga_timing_pkg: 640x480 timing constants (shared with hvsync_generator), coordinate widths (X_W=10, Y_W=9, PIX_W=3), FSM state enum.
- One sub-module, vga_sync_detect: input register, polarity normalisation, assert-edge detect. Instantiated for hsync and vsync.

Test Plan:
- Nominal 640x480 stream from hvsync_generator loopback -> locked=1 at 2nd vs_edge after reset; following frame gives exactly 307200 wr_en; first write (0,0), last (639,479); no err.
- pixel_in = CounterX[2:0] -> every write has wr_pixel == wr_x[2:0]; wr_pixel equals pixel_in delayed 2 clk.
- One 799-clock line injected in a locked frame -> err pulse at that hs_edge; locked=0 and wr_en=0 next cycle; relock after 2 further good vs_edges.
- hsync held inactive while locked -> err when hcount hits 800; state SEARCH; no writes.
- rst high for 1 cycle mid active line (x=300, y=200) -> all outputs 0 next cycle; locked returns only after 2 vs_edges.
- CRC_EN, all pixels 3'b000 -> frame_crc=0x00 with crc_valid pulse at next frame_start; pattern x[2:0] -> frame_crc matches reference model; a frame with a violation gives no crc_valid.
